stu_cntl: RTL

STU_CNTL -- requirements
Module: stu_cntl

---
 rtl/stu_cntl_pkg.sv | 28 ++
 rtl/stu_fifo.sv | 61 ++++++
 rtl/stu_cntl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/stu_cntl_pkg.sv
// Shared definitions for stu_cntl: framing encodings, FSM states, default widths.
package stu_cntl_pkg;

    localparam int unsigned DataWDef     = 64;
    localparam int unsigned TagWDef      = 8;
    localparam int unsigned FifoDepthDef = 8;

    // Free entries that must remain after this cycle for ready to stay high.
    localparam int unsigned ReadyMargin  = 3;

    typedef enum logic [1:0] {
        CntlMom    = 2'b00,
        CntlSom    = 2'b01,
        CntlEom    = 2'b10,
        CntlSomEom = 2'b11
    } cntl_e;

    typedef enum logic {
        StIdle,
        StInPkt
    } state_e;

    // EOM and SOM_EOM both close a packet.
    function automatic logic is_eop(logic [1:0] cntl);
        return cntl[1];
    endfunction

endpackage

// File: rtl/stu_fifo.sv
// Power-of-two circular buffer with occupancy count; head is read combinationally.
module stu_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 74
) (
    input  logic                     clk,
    input  logic                     reset_poweron,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en, rd_en;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem[rptr_q];

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_comb begin
        count_d = count_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + 1'b1;
            if (rd_en) rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/stu_cntl.sv
// Stack upstream controller: input register, framing check, buffering to the rdp.
// Optional framing checker enabled by defining STUC_FRAMING_CHECK_EN.
module stu_cntl
    import stu_cntl_pkg::*;
#(
    parameter int unsigned DATA_W     = DataWDef,
    parameter int unsigned TAG_W      = TagWDef,
    parameter int unsigned FIFO_DEPTH = FifoDepthDef
) (
    input  logic              clk,
    input  logic              reset_poweron,

    input  logic              sui__stuc__valid,
    input  logic [1:0]        sui__stuc__cntl,
    input  logic [TAG_W-1:0]  sui__stuc__tag,
    input  logic [DATA_W-1:0] sui__stuc__data,
    output logic              stuc__sui__ready,

    output logic              stuc__rdp__valid,
    output logic [1:0]        stuc__rdp__cntl,
    output logic [TAG_W-1:0]  stuc__rdp__tag,
    output logic [DATA_W-1:0] stuc__rdp__data,
    input  logic              rdp__stuc__ready,

    output logic              stuc__err_sticky,
    output logic [7:0]        stuc__err_count,
    output logic [15:0]       stuc__pkt_count
);

    localparam int unsigned W  = 2 + TAG_W + DATA_W;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic              d1_valid_q;
    logic [1:0]        d1_cntl_q;
    logic [TAG_W-1:0]  d1_tag_q;
    logic [DATA_W-1:0] d1_data_q;

    logic              frame_ok;
    logic              overflow;
    logic              push, pop;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count, count_next;
    logic [W-1:0]      fifo_head, rdp_word;
    logic              ready_q;
    logic [15:0]       pkt_count_q;

    // Input words are captured unconditionally; ready is only advisory.
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            d1_valid_q <= 1'b0;
            d1_cntl_q  <= '0;
            d1_tag_q   <= '0;
            d1_data_q  <= '0;
        end else begin
            d1_valid_q <= sui__stuc__valid;
            d1_cntl_q  <= sui__stuc__cntl;
            d1_tag_q   <= sui__stuc__tag;
            d1_data_q  <= sui__stuc__data;
        end
    end

`ifdef STUC_FRAMING_CHECK_EN
    state_e            state_q, state_d;
    logic [TAG_W-1:0]  pkt_tag_q, pkt_tag_d;
    cntl_e             d1_kind;
    logic              tag_match;
    logic              frame_err;
    logic [7:0]        err_count_q;
    logic              err_sticky_q;

    assign d1_kind   = cntl_e'(d1_cntl_q);
    assign tag_match = (d1_tag_q == pkt_tag_q);

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            state_q   <= StIdle;
            pkt_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            pkt_tag_q <= pkt_tag_d;
        end
    end

    // The FSM tracks framing even if the word is later lost to overflow.
    always_comb begin
        state_d   = state_q;
        pkt_tag_d = pkt_tag_q;
        if (d1_valid_q) begin
            case (state_q)
                StIdle: begin
                    if (d1_kind == CntlSom) begin
                        state_d   = StInPkt;
                        pkt_tag_d = d1_tag_q;
                    end
                end
                StInPkt: begin
                    if (d1_kind == CntlEom && tag_match) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        frame_ok = 1'b0;
        if (d1_valid_q) begin
            case (state_q)
                StIdle:  frame_ok = (d1_kind == CntlSom) || (d1_kind == CntlSomEom);
                StInPkt: frame_ok = tag_match && ((d1_kind == CntlMom) || (d1_kind == CntlEom));
                default: frame_ok = 1'b0;
            endcase
        end
    end

    assign frame_err = d1_valid_q && !frame_ok;

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            err_count_q  <= '0;
            err_sticky_q <= 1'b0;
        end else if (frame_err || overflow) begin
            err_sticky_q <= 1'b1;
            if (err_count_q != 8'hFF) err_count_q <= err_count_q + 1'b1;
        end
    end

    assign stuc__err_sticky = err_sticky_q;
    assign stuc__err_count  = err_count_q;
`else
    assign frame_ok         = 1'b1;
    assign stuc__err_sticky = 1'b0;
    assign stuc__err_count  = '0;
`endif

    assign pop      = !fifo_empty && rdp__stuc__ready;
    assign overflow = d1_valid_q && frame_ok && fifo_full && !pop;
    assign push     = d1_valid_q && frame_ok && !overflow;

    stu_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (W)
    ) u_fifo (
        .clk           (clk),
        .reset_poweron (reset_poweron),
        .push          (push),
        .wdata         ({d1_cntl_q, d1_tag_q, d1_data_q}),
        .pop           (pop),
        .rdata         (fifo_head),
        .full          (fifo_full),
        .empty         (fifo_empty),
        .count         (fifo_count)
    );

    assign count_next = fifo_count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

    // Ready reflects occupancy after this edge; the margin covers the word in d1.
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= (count_next <= CW'(FIFO_DEPTH - ReadyMargin));
        end
    end

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            pkt_count_q <= '0;
        end else if (pop && is_eop(fifo_head[W-1 -: 2])) begin
            pkt_count_q <= pkt_count_q + 1'b1;
        end
    end

    // Fields read as zero when nothing is buffered, so a flushed FIFO shows no stale data.
    assign rdp_word = fifo_empty ? '0 : fifo_head;

    assign stuc__sui__ready = ready_q;
    assign stuc__rdp__valid = !fifo_empty;
    assign stuc__rdp__cntl  = rdp_word[W-1 -: 2];
    assign stuc__rdp__tag   = rdp_word[DATA_W +: TAG_W];
    assign stuc__rdp__data  = rdp_word[DATA_W-1:0];
    assign stuc__pkt_count  = pkt_count_q;

endmodule
